jtcps_vtiming: RTL and testbench

- Parametrised raster timing generator; next generation of the fixed CPS1 timing block that feeds the video top.
- Produces hdump/vdump counters, render-ahead line numbers, sync and blank signals, and the per-line render start pulse.
- Adds configurable raster geometry, N-line render lookahead, and a delayed-blank pipeline of configurable depth.
- Sits beside the MMR; all scroll/object/colmix engines consume its outputs. Defaults reproduce CPS1 timing.

---
 rtl/jtcps_timing_pkg.sv | 47 ++++
 rtl/jtcps_vtiming_dly.sv | 52 +++++
 rtl/jtcps_vtiming.sv | 204 ++++++++++++++++++++
 tb/tb_jtcps_vtiming.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/jtcps_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtcps_timing_pkg
// Description : Shared raster-timing constants (CPS1 default geometry) and
//               small helper functions used by the timing generator.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package jtcps_timing_pkg;

    // CPS1 raster geometry
    localparam int unsigned CPS1_H_TOTAL  = 512;
    localparam int unsigned CPS1_HB_END   = 64;
    localparam int unsigned CPS1_HB_START = 448;
    localparam int unsigned CPS1_HS_START = 474;
    localparam int unsigned CPS1_HS_END   = 506;
    localparam int unsigned CPS1_V_TOTAL  = 262;
    localparam int unsigned CPS1_VB_END   = 16;
    localparam int unsigned CPS1_VB_START = 240;
    localparam int unsigned CPS1_VS_START = 244;
    localparam int unsigned CPS1_VS_END   = 247;

    // (value + step) mod total. Only valid for value < total and
    // step < total, so a single conditional subtraction is enough.
    function automatic int unsigned mod_inc(
        input int unsigned value,
        input int unsigned total,
        input int unsigned step
    );
        int unsigned sum;
        sum = value + step;
        if (sum >= total) begin
            sum = sum - total;
        end
        return sum;
    endfunction

    // lo <= value < hi
    function automatic logic in_range(
        input int unsigned value,
        input int unsigned lo,
        input int unsigned hi
    );
        return (value >= lo) && (value < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtcps_vtiming_dly.sv
`default_nettype none
// ============================================================================
// Module      : jtcps_vtiming_dly
// Description : DEPTH-stage shift register advanced on the pixel clock
//               enable. DEPTH=0 is a straight wire.
// Ports       : clk   - system clock
//               rst   - asynchronous active-high reset (clears all stages)
//               cen_i - shift enable
//               d_i   - serial input
//               q_o   - output of the last stage
// Revision    : 1.0 - initial release
// ============================================================================
module jtcps_vtiming_dly #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cen_i,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, cen_i};
            assign q_o       = d_i;
        end else if (DEPTH == 1) begin : g_single
            logic pipe_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= 1'b0;
                end else if (cen_i) begin
                    pipe_q <= d_i;
                end
            end
            assign q_o = pipe_q;
        end else begin : g_shift
            logic [DEPTH-1:0] pipe_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= '0;
                end else if (cen_i) begin
                    pipe_q <= {pipe_q[DEPTH-2:0], d_i};
                end
            end
            assign q_o = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/jtcps_vtiming.sv
`default_nettype none
// ============================================================================
// Module      : jtcps_vtiming
// Description : Parametrised raster timing generator. Produces pixel/line
//               counters, render-ahead line numbers, sync/blank flags, a
//               per-line start pulse and delayed blanking. Defaults give
//               CPS1 timing.
// Ports       : clk, rst (async, active-high), cen (pixel enable)
//               hdump/vdump        - current pixel / line
//               vrender/vrender1   - line being rendered and the one after
//               start              - one-clk pulse when hdump becomes START_H
//               HS/VS/HB/VB        - sync and blank, active-high
//               preVB              - vrender lies in vertical blanking
//               LHBL_dly/LVBL_dly  - ~HB / ~VB delayed BLANK_DLY cen ticks
//               frame_cnt          - frame counter
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module jtcps_vtiming
    import jtcps_timing_pkg::*;
#(
    parameter int unsigned HW        = 9,
    parameter int unsigned VW        = 9,
    parameter int unsigned H_TOTAL   = CPS1_H_TOTAL,
    parameter int unsigned HB_END    = CPS1_HB_END,
    parameter int unsigned HB_START  = CPS1_HB_START,
    parameter int unsigned HS_START  = CPS1_HS_START,
    parameter int unsigned HS_END    = CPS1_HS_END,
    parameter int unsigned V_TOTAL   = CPS1_V_TOTAL,
    parameter int unsigned VB_END    = CPS1_VB_END,
    parameter int unsigned VB_START  = CPS1_VB_START,
    parameter int unsigned VS_START  = CPS1_VS_START,
    parameter int unsigned VS_END    = CPS1_VS_END,
    parameter int unsigned LOOKAHEAD = 1,
    parameter int unsigned START_H   = 0,
    parameter int unsigned BLANK_DLY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    output logic [HW-1:0] hdump,
    output logic [VW-1:0] vdump,
    output logic [VW-1:0] vrender,
    output logic [VW-1:0] vrender1,
    output logic          start,
    output logic          HS,
    output logic          VS,
    output logic          HB,
    output logic          VB,
    output logic          preVB,
    output logic          LHBL_dly,
    output logic          LVBL_dly,
    output logic [7:0]    frame_cnt
);

    localparam logic [HW-1:0] c_H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] c_V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] c_START_H = HW'(START_H);
    localparam logic [VW-1:0] c_VR0     = VW'(mod_inc(0, V_TOTAL, LOOKAHEAD));
    localparam logic [VW-1:0] c_VR1     = VW'(mod_inc(0, V_TOTAL, LOOKAHEAD + 1));
    localparam logic          c_PREVB0  = !in_range(mod_inc(0, V_TOTAL, LOOKAHEAD),
                                                    VB_END, VB_START);

    // ------------------------------------------------------------------
    // Elaboration-time geometry checks
    // ------------------------------------------------------------------
`ifdef SIMULATION
    generate
        if (!(HB_END < HB_START && HB_START <= HS_START && HS_START < HS_END &&
              HS_END <= H_TOTAL && START_H < H_TOTAL)) begin : g_chk_hgeom
            $error("jtcps_vtiming: horizontal geometry parameters out of order");
        end
        if (!(VB_END < VB_START && VB_START <= VS_START && VS_START < VS_END &&
              VS_END <= V_TOTAL)) begin : g_chk_vgeom
            $error("jtcps_vtiming: vertical geometry parameters out of order");
        end
        if (LOOKAHEAD < 1 || LOOKAHEAD > 4) begin : g_chk_look
            $error("jtcps_vtiming: LOOKAHEAD must be 1..4");
        end
        if (BLANK_DLY > 15) begin : g_chk_dly
            $error("jtcps_vtiming: BLANK_DLY must be 0..15");
        end
        if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_chk_width
            $error("jtcps_vtiming: counter width too small for raster size");
        end
    endgenerate
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HW-1:0] hdump_q,    hdump_d;
    logic [VW-1:0] vdump_q,    vdump_d;
    logic [VW-1:0] vrender_q,  vrender_d;
    logic [VW-1:0] vrender1_q, vrender1_d;
    logic [7:0]    frame_q,    frame_d;
    logic          hb_q, hb_d, hs_q, hs_d;
    logic          vb_q, vb_d, vs_q, vs_d;
    logic          prevb_q, prevb_d;
    logic          start_q, start_d;
    logic          h_wrap, v_wrap;

    // Every flag is decoded from the *next* counter value so it lands in
    // the same clk as the counter it describes.
    always_comb begin
        h_wrap     = cen && (hdump_q == c_H_LAST);
        v_wrap     = h_wrap && (vdump_q == c_V_LAST);

        hdump_d    = hdump_q;
        vdump_d    = vdump_q;
        vrender_d  = vrender_q;
        vrender1_d = vrender1_q;
        frame_d    = frame_q;
        hb_d       = hb_q;
        hs_d       = hs_q;
        vb_d       = vb_q;
        vs_d       = vs_q;
        prevb_d    = prevb_q;

        if (cen) begin
            hdump_d = h_wrap ? '0 : hdump_q + 1'b1;
            hb_d    = !in_range(32'(hdump_d), HB_END, HB_START);
            hs_d    =  in_range(32'(hdump_d), HS_START, HS_END);
        end

        // Vertical state only moves on the line wrap.
        if (h_wrap) begin
            vdump_d    = v_wrap ? '0 : vdump_q + 1'b1;
            vrender_d  = VW'(mod_inc(32'(vrender_q),  V_TOTAL, 1));
            vrender1_d = VW'(mod_inc(32'(vrender1_q), V_TOTAL, 1));
            vb_d       = !in_range(32'(vdump_d), VB_END, VB_START);
            vs_d       =  in_range(32'(vdump_d), VS_START, VS_END);
            prevb_d    = !in_range(32'(vrender_d), VB_END, VB_START);
        end

        if (v_wrap) begin
            frame_d = frame_q + 8'd1;
        end

        // Only a cen tick that lands on START_H produces a pulse, so the
        // reset value of hdump never triggers one.
        start_d = cen && (hdump_d == c_START_H);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdump_q    <= '0;
            vdump_q    <= '0;
            vrender_q  <= c_VR0;
            vrender1_q <= c_VR1;
            frame_q    <= 8'd0;
            hb_q       <= 1'b1;
            hs_q       <= 1'b0;
            vb_q       <= 1'b1;
            vs_q       <= 1'b0;
            prevb_q    <= c_PREVB0;
            start_q    <= 1'b0;
        end else begin
            hdump_q    <= hdump_d;
            vdump_q    <= vdump_d;
            vrender_q  <= vrender_d;
            vrender1_q <= vrender1_d;
            frame_q    <= frame_d;
            hb_q       <= hb_d;
            hs_q       <= hs_d;
            vb_q       <= vb_d;
            vs_q       <= vs_d;
            prevb_q    <= prevb_d;
            start_q    <= start_d;
        end
    end

    // ------------------------------------------------------------------
    // Delayed blanking
    // ------------------------------------------------------------------
    jtcps_vtiming_dly #(.DEPTH(BLANK_DLY)) u_lhbl_dly (
        .clk   (clk),
        .rst   (rst),
        .cen_i (cen),
        .d_i   (!hb_q),
        .q_o   (LHBL_dly)
    );

    jtcps_vtiming_dly #(.DEPTH(BLANK_DLY)) u_lvbl_dly (
        .clk   (clk),
        .rst   (rst),
        .cen_i (cen),
        .d_i   (!vb_q),
        .q_o   (LVBL_dly)
    );

    assign hdump     = hdump_q;
    assign vdump     = vdump_q;
    assign vrender   = vrender_q;
    assign vrender1  = vrender1_q;
    assign frame_cnt = frame_q;
    assign start     = start_q;
    assign HB        = hb_q;
    assign HS        = hs_q;
    assign VB        = vb_q;
    assign VS        = vs_q;
    assign preVB     = prevb_q;

endmodule
`default_nettype wire

// File: tb/tb_jtcps_vtiming.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtcps_vtiming
// Description : Directed self-checking bench. Instance A uses the CPS1
//               defaults; instance B uses a short 32-pixel line with
//               LOOKAHEAD=3 and BLANK_DLY=0 so a full frame is cheap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtcps_vtiming;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen_a = 1'b0;
    logic cen_b = 1'b0;

    always #5 clk = ~clk;

    logic [8:0] a_h, a_v, a_vr, a_vr1;
    logic [7:0] a_fc;
    logic       a_start, a_hs, a_vs, a_hb, a_vb, a_prevb, a_lhbl, a_lvbl;
    logic [8:0] b_h, b_v, b_vr, b_vr1;
    logic [7:0] b_fc;
    logic       b_start, b_hs, b_vs, b_hb, b_vb, b_prevb, b_lhbl, b_lvbl;

    jtcps_vtiming u_dut_a (
        .clk(clk), .rst(rst), .cen(cen_a),
        .hdump(a_h), .vdump(a_v), .vrender(a_vr), .vrender1(a_vr1),
        .start(a_start), .HS(a_hs), .VS(a_vs), .HB(a_hb), .VB(a_vb),
        .preVB(a_prevb), .LHBL_dly(a_lhbl), .LVBL_dly(a_lvbl),
        .frame_cnt(a_fc)
    );

    jtcps_vtiming #(
        .H_TOTAL(32), .HB_END(4), .HB_START(28), .HS_START(29), .HS_END(31),
        .LOOKAHEAD(3), .BLANK_DLY(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .cen(cen_b),
        .hdump(b_h), .vdump(b_v), .vrender(b_vr), .vrender1(b_vr1),
        .start(b_start), .HS(b_hs), .VS(b_vs), .HB(b_hb), .VB(b_vb),
        .preVB(b_prevb), .LHBL_dly(b_lhbl), .LVBL_dly(b_lvbl),
        .frame_cnt(b_fc)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Hand-written window decodes for the two geometries
    function automatic logic hb_a(input int h); return (h < 64) || (h >= 448); endfunction
    function automatic logic hs_a(input int h); return (h >= 474) && (h < 506); endfunction
    function automatic logic hb_b(input int h); return (h < 4) || (h >= 28);    endfunction
    function automatic logic hs_b(input int h); return (h >= 29) && (h < 31);   endfunction
    function automatic logic vb_f(input int v); return (v < 16) || (v >= 240);  endfunction
    function automatic logic vs_f(input int v); return (v >= 244) && (v < 247); endfunction

    initial begin
        int ticks;
        int hb_fall;
        int lhbl_rise;
        int starts;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_h",     a_h, 0);
        chk("rst_a_v",     a_v, 0);
        chk("rst_a_vr",    a_vr, 1);
        chk("rst_a_vr1",   a_vr1, 2);
        chk("rst_a_hb",    a_hb, 1);
        chk("rst_a_vb",    a_vb, 1);
        chk("rst_a_hs",    a_hs, 0);
        chk("rst_a_vs",    a_vs, 0);
        chk("rst_a_prevb", a_prevb, 1);
        chk("rst_a_start", a_start, 0);
        chk("rst_a_lhbl",  a_lhbl, 0);
        chk("rst_a_lvbl",  a_lvbl, 0);
        chk("rst_a_fc",    a_fc, 0);
        chk("rst_b_vr",    b_vr, 3);
        chk("rst_b_vr1",   b_vr1, 4);
        rst = 1'b0;

        // ---------------- A: cen every clk ----------------
        cen_a = 1'b1;
        for (int k = 1; k <= 812; k++) begin
            @(posedge clk);
            #1;
            chk("a1_h",     a_h, k % 512);
            chk("a1_v",     a_v, k / 512);
            chk("a1_vr",    a_vr, k / 512 + 1);
            chk("a1_hb",    a_hb, hb_a(k % 512));
            chk("a1_hs",    a_hs, hs_a(k % 512));
            chk("a1_start", a_start, (k % 512) == 0);
            chk("a1_lhbl",  a_lhbl, (k >= 4) ? !hb_a((k - 4) % 512) : 1'b0);
        end
        chk("a1_end_h", a_h, 300);
        chk("a1_end_v", a_v, 1);

        // ---------------- A: asynchronous reset mid-line ----------------
        cen_a = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_a_h",    a_h, 0);
        chk("arst_a_v",    a_v, 0);
        chk("arst_a_hb",   a_hb, 1);
        chk("arst_a_vb",   a_vb, 1);
        chk("arst_a_lhbl", a_lhbl, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- A: cen 1 clk in 4 ----------------
        ticks     = 0;
        hb_fall   = -1;
        lhbl_rise = -1;
        for (int c = 0; c < 2400; c++) begin
            cen_a = (c % 4) == 0;
            @(posedge clk);
            #1;
            if (cen_a) ticks++;
            chk("a2_h",     a_h, ticks % 512);
            chk("a2_start", a_start, cen_a && (ticks % 512) == 0 && ticks > 0);
            chk("a2_lhbl",  a_lhbl, (ticks >= 4) ? !hb_a((ticks - 4) % 512) : 1'b0);
            if (a_hb == 1'b0 && hb_fall < 0)  hb_fall   = c;
            if (a_lhbl == 1'b1 && lhbl_rise < 0) lhbl_rise = c;
        end
        chk("a2_lhbl_lag", lhbl_rise - hb_fall, 16);
        cen_a = 1'b0;

        // B sat idle with cen low the whole time
        chk("b_idle_h",     b_h, 0);
        chk("b_idle_start", b_start, 0);

        // ---------------- B: full frame and beyond ----------------
        cen_b  = 1'b1;
        starts = 0;
        for (int k = 1; k <= 11604; k++) begin
            int h, line, v, vr;
            @(posedge clk);
            #1;
            h    = k % 32;
            line = k / 32;
            v    = line % 262;
            vr   = (v + 3) % 262;
            if (b_start) starts++;
            chk("b_h",     b_h, h);
            chk("b_v",     b_v, v);
            chk("b_vr",    b_vr, vr);
            chk("b_vr1",   b_vr1, (v + 4) % 262);
            chk("b_hb",    b_hb, hb_b(h));
            chk("b_hs",    b_hs, hs_b(h));
            chk("b_vb",    b_vb, vb_f(v));
            chk("b_vs",    b_vs, vs_f(v));
            chk("b_prevb", b_prevb, vb_f(vr));
            chk("b_start", b_start, h == 0);
            chk("b_lhbl",  b_lhbl, !hb_b(h));
            chk("b_lvbl",  b_lvbl, !vb_f(v));
            chk("b_fc",    b_fc, (line / 262) % 256);
            if (k == 7583) chk("b_prevb_239pre", b_prevb, 0);
            if (k == 7584) chk("b_prevb_rise",   b_prevb, 1);
            if (k == 7679) chk("b_vb_239",       b_vb, 0);
            if (k == 7680) chk("b_vb_240",       b_vb, 1);
            if (k == 8320) begin
                chk("b_wrap_vr",  b_vr, 1);
                chk("b_wrap_vr1", b_vr1, 2);
            end
            if (k == 8384) begin
                chk("b_frame_starts", starts, 262);
                chk("b_frame_cnt",    b_fc, 1);
            end
        end

        // ---------------- B: asynchronous reset at vdump=100 ----------------
        chk("b_pre_rst_v", b_v, 100);
        cen_b = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("brst_h",     b_h, 0);
        chk("brst_v",     b_v, 0);
        chk("brst_vr",    b_vr, 3);
        chk("brst_vr1",   b_vr1, 4);
        chk("brst_hb",    b_hb, 1);
        chk("brst_vb",    b_vb, 1);
        chk("brst_prevb", b_prevb, 1);
        chk("brst_fc",    b_fc, 0);
        chk("brst_lhbl",  b_lhbl, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cen_b = 1'b1;
        @(posedge clk);
        #1;
        chk("brel_h", b_h, 1);
        chk("brel_v", b_v, 0);
        cen_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
